// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, datapath
// select codes, ALU/immediate codes and the opcodes the decoder recognises.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BRANCH, S_LUI, S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  localparam int unsigned ALU_ADD = 0, ALU_SUB = 1, ALU_AND = 2, ALU_OR  = 3, ALU_XOR = 4;
  localparam int unsigned ALU_SLT = 5, ALU_SLL = 6, ALU_SRL = 7, ALU_SRA = 8, ALU_SLTU = 9;

  localparam int unsigned IMM_I = 0, IMM_S = 1, IMM_B = 2, IMM_J = 3, IMM_U = 4;

  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10, RES_IMMEXT = 2'b11;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_REG = 2'b10;
  localparam logic [1:0] SRCB_WD = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Immediate format implied by the opcode; anything unrecognised reads as I-type.
  function automatic int unsigned imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      OP_LUI:    return IMM_U;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder: fixed ADD/SUB for address and compare steps, otherwise
// decoded from funct3/funct7b5, with SUB only for register-register ops.
module alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  alu_op_e              alu_op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 op5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  int unsigned code;

  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  code = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  code = ALU_SLL;
          3'b010:  code = ALU_SLT;
          3'b011:  code = ALU_SLTU;
          3'b100:  code = ALU_XOR;
          3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  code = ALU_OR;
          default: code = ALU_AND;
        endcase
      end
    endcase
    alu_control = ALUCTRL_W'(code);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: main FSM, branch resolution, memory-ready
// timeout and sticky fault. All outputs are combinational from state + inputs.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int          ALUCTRL_W   = 4,
  parameter int          IMMSRC_W    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [IMMSRC_W-1:0]  ImmSrc,
  output logic                 retire,
  output logic                 fault
);

  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  alu_op_e           alu_op;
  logic              taken, branch_ok;
  logic              mem_state, timeout_hit;

  assign mem_state   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
  assign timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (cnt_q == CNT_LAST);

  always_comb begin
    taken     = 1'b0;
    branch_ok = 1'b1;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: branch_ok = 1'b0;
    endcase
  end

  // NOTE: every output and state_d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    alu_op    = ALUOP_ADD;
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_WD;
    ImmSrc    = IMMSRC_W'(imm_src_for(op));
    retire    = 1'b0;
    fault     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_REG;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_REG;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_BRANCH: begin
        ALUSrcA = SRCA_REG;
        alu_op  = ALUOP_SUB;
        // Reserved funct3 codes fault without retiring or redirecting the PC.
        if (branch_ok) begin
          PCWrite = taken;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_LUI: begin
        ResultSrc = RES_IMMEXT;
        ImmSrc    = IMMSRC_W'(IMM_U);
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      default: fault = 1'b1;
    endcase

    // A ready on the last allowed cycle wins over the timeout (timeout_hit needs !mem_ready).
    if (timeout_hit) state_d = S_FAULT;
  end

  always_comb begin
    cnt_d = '0;
    if (mem_state && !mem_ready && (state_d == state_q))
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  alu_decoder #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
